// File: rtl/des_ks_pkg.sv
// Shared definitions for the streaming DES/TDES key schedule: state and C/D
// operation enums, the FIPS 46-3 shift table, and the PC1/PC2 permutations.
package des_ks_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} ks_state_e;

  typedef enum logic [1:0] {CD_HOLD, CD_LOAD, CD_ROTL, CD_ROTR} cd_op_e;

  // Left-shift amount applied before generating round key n+1 (0-based index).
  localparam logic [1:0] KS_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // FIPS bit numbers (1 = MSB of the 64-bit key) selected by PC1.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // FIPS bit numbers (1 = MSB of C) selected by PC2 from the 56-bit C||D.
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic bit ks_num_keys_ok(int n);
    return (n == 1) || (n == 3);
  endfunction

  function automatic logic ks_shift_is_two(logic [3:0] idx);
    return KS_SHIFT[idx] == 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(logic [27:0] x, logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(logic [27:0] x, logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // C and D halves rotate independently.
  function automatic logic [55:0] cd_rotl(logic [55:0] cd, logic two);
    return {rotl28(cd[55:28], two), rotl28(cd[27:0], two)};
  endfunction

  function automatic logic [55:0] cd_rotr(logic [55:0] cd, logic two);
    return {rotr28(cd[55:28], two), rotr28(cd[27:0], two)};
  endfunction

  function automatic logic [55:0] des_pc1(logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] des_pc2(logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  // Encrypt starts from C1/D1 (one left shift); decrypt starts from C0/D0,
  // which equals C16/D16 because the total rotation is a full 28 bits.
  function automatic logic [55:0] ks_load_cd(logic [63:0] k, logic dec);
    logic [55:0] p;
    p = des_pc1(k);
    return dec ? p : cd_rotl(p, 1'b0);
  endfunction

endpackage

// File: rtl/des_ks_cd_reg.sv
// 56-bit C/D state register: load, rotate left/right by 1 or 2, or hold.
module des_ks_cd_reg import des_ks_pkg::*; (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  op,
  input  logic        two,
  input  logic [55:0] load_val,
  output logic [55:0] cd
);

  logic [55:0] cd_d, cd_q;

  // Select the next C/D value from the requested operation.
  always_comb begin
    cd_d = cd_q;
    case (op)
      CD_LOAD: cd_d = load_val;
      CD_ROTL: cd_d = cd_rotl(cd_q, two);
      CD_ROTR: cd_d = cd_rotr(cd_q, two);
      default: cd_d = cd_q;
    endcase
  end

  // C/D storage, cleared by reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cd_q <= '0;
    else       cd_q <= cd_d;
  end

  assign cd = cd_q;

endmodule

// File: rtl/des_key_sched_stream.sv
// Iterative DES/TDES key schedule streaming one 48-bit round key per
// valid/ready handshake. Optional key byte parity check is built when
// DES_KEY_PARITY_CHK_EN is defined; otherwise key_par_err is tied low.
module des_key_sched_stream import des_ks_pkg::*; #(
  parameter int NUM_KEYS = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [64*NUM_KEYS-1:0] req_key,
  input  logic                  req_decrypt,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [47:0]           rk_data,
  output logic [3:0]            rk_round,
  output logic [1:0]            rk_key_idx,
  output logic                  rk_last,
  output logic                  key_par_err
);

  if (!ks_num_keys_ok(NUM_KEYS)) begin : g_bad_num_keys
    $error("des_key_sched_stream: NUM_KEYS must be 1 or 3");
  end

  localparam logic [1:0] LAST_SEQ = 2'(NUM_KEYS - 1);

  ks_state_e             state_q, state_d;
  logic [1:0]            seq_q, seq_d;
  logic [3:0]            round_q, round_d;
  logic                  dec_q, dec_d;
  logic [64*NUM_KEYS-1:0] key_q, key_d;

  logic [1:0]  key_idx, nxt_seq, nxt_idx, first_idx;
  logic        cur_dec;
  logic [63:0] nxt_key, first_key;
  cd_op_e      cd_op;
  logic        cd_two;
  logic [55:0] cd_load, cd;

  // Key order: encrypt walks K1..K3, decrypt walks K3..K1; direction
  // alternates per key around the requested one (EDE).
  always_comb begin
    key_idx   = dec_q ? (LAST_SEQ - seq_q) : seq_q;
    cur_dec   = dec_q ^ seq_q[0];
    nxt_seq   = seq_q + 2'd1;
    nxt_idx   = dec_q ? (LAST_SEQ - nxt_seq) : nxt_seq;
    if (nxt_idx > LAST_SEQ) nxt_idx = LAST_SEQ;
    nxt_key   = key_q[64*int'(nxt_idx) +: 64];
    first_idx = req_decrypt ? LAST_SEQ : 2'd0;
    first_key = req_key[64*int'(first_idx) +: 64];
  end

  // FSM next state, counters and C/D control; flush overrides everything.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    round_d = round_q;
    dec_d   = dec_q;
    key_d   = key_q;
    cd_op   = CD_HOLD;
    cd_two  = 1'b0;
    cd_load = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_RUN;
          seq_d   = '0;
          round_d = '0;
          dec_d   = req_decrypt;
          key_d   = req_key;
          cd_op   = CD_LOAD;
          cd_load = ks_load_cd(first_key, req_decrypt);
        end
      end
      ST_RUN: begin
        if (rk_ready) begin
          if (round_q != 4'd15) begin
            round_d = round_q + 4'd1;
            cd_op   = cur_dec ? CD_ROTR : CD_ROTL;
            cd_two  = cur_dec ? ks_shift_is_two(4'd15 - round_q)
                              : ks_shift_is_two(round_q + 4'd1);
          end else if (seq_q != LAST_SEQ) begin
            seq_d   = nxt_seq;
            round_d = '0;
            cd_op   = CD_LOAD;
            cd_load = ks_load_cd(nxt_key, dec_q ^ nxt_seq[0]);
          end else begin
            state_d = ST_IDLE;
            seq_d   = '0;
            round_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      seq_d   = '0;
      round_d = '0;
      dec_d   = dec_q;
      key_d   = key_q;
      cd_op   = CD_HOLD;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  // Captured request keys; only meaningful while a request is running.
  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  des_ks_cd_reg u_cd (
    .clk      (clk),
    .nrst     (nrst),
    .op       (cd_op),
    .two      (cd_two),
    .load_val (cd_load),
    .cd       (cd)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign rk_valid   = (state_q == ST_RUN);
  assign rk_data    = rk_valid ? des_pc2(cd) : 48'd0;
  assign rk_round   = round_q;
  assign rk_key_idx = rk_valid ? key_idx : 2'd0;
  assign rk_last    = rk_valid && (round_q == 4'd15) && (seq_q == LAST_SEQ);

`ifdef DES_KEY_PARITY_CHK_EN
  logic par_bad, par_err_d, par_err_q;

  // Every key byte must have odd parity; result latched at acceptance.
  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8*NUM_KEYS; b++)
      if (!(^req_key[8*b +: 8])) par_bad = 1'b1;
    par_err_d = par_err_q;
    if (flush)                                   par_err_d = 1'b0;
    else if (state_q == ST_IDLE && req_valid)    par_err_d = par_bad;
  end

  // Parity error flag register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end

  assign key_par_err = par_err_q;
`else
  assign key_par_err = 1'b0;
`endif

endmodule
